// File: rtl/tcm_inst_load_port.sv
// Instruction-TCM loader port: buffers bench writes in a small FIFO, commits them
// to the single-port RAM ahead of core fetches, and holds the core in reset until loaded.
module tcm_inst_load_port #(
  parameter int FIFO_DEPTH = 4,
  parameter int MEM_WORDS  = 16384,
  localparam int AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          rst_cpu_i,
  input  logic [3:0]    tb_inst_we_i,
  input  logic [31:0]   tb_inst_addr_i,
  input  logic [31:0]   tb_inst_data_i,
  input  logic          fetch_rd_i,
  input  logic [31:0]   fetch_pc_i,
  output logic          fetch_accept_o,
  output logic          fetch_valid_o,
  output logic [31:0]   fetch_inst_o,
  input  logic          mem_ready_i,
  output logic [AW-1:0] mem_addr_o,
  output logic [3:0]    mem_wr_o,
  output logic          mem_rd_o,
  output logic [31:0]   mem_data_o,
  input  logic [31:0]   mem_data_i,
  output logic          cpu_rst_o,
  output logic [15:0]   load_cnt_o,
  output logic          overflow_o,
  output logic          addr_err_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] PTR_ONE = 1;

  typedef enum logic [1:0] {S_LOAD, S_HOLD, S_RUN} state_t;

  state_t          r_state, w_state_nxt;
  logic [PW:0]     r_wptr, r_rptr;
  logic [AW-1:0]   r_fifo_addr [FIFO_DEPTH];
  logic [3:0]      r_fifo_we   [FIFO_DEPTH];
  logic [31:0]     r_fifo_data [FIFO_DEPTH];
  logic [AW-1:0]   r_last_addr;
  logic [31:0]     r_last_data;
  logic            r_fetch_valid;
  logic [15:0]     r_load_cnt;
  logic            r_overflow, r_addr_err;

  logic [29:0]     w_word;
  logic            w_wr_req, w_addr_bad, w_empty, w_full, w_pop, w_push, w_fetch;
  logic            w_unused;

  assign w_word     = tb_inst_addr_i[31:2];
  assign w_wr_req   = |tb_inst_we_i;
  assign w_addr_bad = w_word >= 30'(MEM_WORDS);
  assign w_empty    = (r_wptr == r_rptr);
  assign w_full     = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign w_pop      = !w_empty && mem_ready_i;
  // A full FIFO still accepts the incoming write when the head drains this cycle.
  assign w_push     = w_wr_req && !w_addr_bad && (!w_full || w_pop);
  assign w_fetch    = (r_state == S_RUN) && w_empty && !w_push && mem_ready_i && fetch_rd_i;

  assign w_unused   = ^{fetch_pc_i, tb_inst_addr_i[1:0]};

  always_comb begin
    mem_addr_o = r_last_addr;
    mem_data_o = r_last_data;
    mem_wr_o   = '0;
    mem_rd_o   = 1'b0;
    if (w_pop) begin
      mem_addr_o = r_fifo_addr[r_rptr[PW-1:0]];
      mem_wr_o   = r_fifo_we[r_rptr[PW-1:0]];
      mem_data_o = r_fifo_data[r_rptr[PW-1:0]];
    end else if (w_fetch) begin
      mem_addr_o = fetch_pc_i[2 +: AW];
      mem_rd_o   = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_LOAD: if (rst_cpu_i) w_state_nxt = S_HOLD;
      S_HOLD: if (!rst_cpu_i && w_empty && !w_push) w_state_nxt = S_RUN;
      S_RUN:  if (rst_cpu_i) w_state_nxt = S_HOLD;
      default: w_state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= S_LOAD;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_last_addr   <= '0;
      r_last_data   <= '0;
      r_fetch_valid <= 1'b0;
      r_load_cnt    <= '0;
      r_overflow    <= 1'b0;
      r_addr_err    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_last_addr   <= mem_addr_o;
      r_last_data   <= mem_data_o;
      r_fetch_valid <= w_fetch;
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
        if (r_load_cnt != 16'hFFFF) r_load_cnt <= r_load_cnt + 16'd1;
      end
      if (w_wr_req && w_addr_bad) r_addr_err <= 1'b1;
      if (w_wr_req && !w_addr_bad && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_addr[r_wptr[PW-1:0]] <= w_word[AW-1:0];
      r_fifo_we[r_wptr[PW-1:0]]   <= tb_inst_we_i;
      r_fifo_data[r_wptr[PW-1:0]] <= tb_inst_data_i;
    end
  end

  assign fetch_accept_o = w_fetch;
  assign fetch_valid_o  = r_fetch_valid;
  assign fetch_inst_o   = r_fetch_valid ? mem_data_i : '0;
  assign cpu_rst_o      = (r_state != S_RUN);
  assign load_cnt_o     = r_load_cnt;
  assign overflow_o     = r_overflow;
  assign addr_err_o     = r_addr_err;

endmodule

// File: tb/tb_tcm_inst_load_port.sv
// Scoreboard bench for tcm_inst_load_port: expected RAM commits and fetch results are
// queued as stimulus is driven and compared when the DUT produces them.
module tb_tcm_inst_load_port;

  logic        clk = 1'b0;
  logic        rst_i, rst_cpu_i, fetch_rd_i, mem_ready_i;
  logic [3:0]  tb_inst_we_i;
  logic [31:0] tb_inst_addr_i, tb_inst_data_i, fetch_pc_i, mem_data_i;
  logic        fetch_accept_o, fetch_valid_o, mem_rd_o, cpu_rst_o, overflow_o, addr_err_o;
  logic [31:0] fetch_inst_o, mem_data_o;
  logic [9:0]  mem_addr_o;
  logic [3:0]  mem_wr_o;
  logic [15:0] load_cnt_o;

  always #5 clk = ~clk;

  tcm_inst_load_port #(.FIFO_DEPTH(4), .MEM_WORDS(1024)) dut (
    .clk_i(clk), .rst_i(rst_i), .rst_cpu_i(rst_cpu_i),
    .tb_inst_we_i(tb_inst_we_i), .tb_inst_addr_i(tb_inst_addr_i), .tb_inst_data_i(tb_inst_data_i),
    .fetch_rd_i(fetch_rd_i), .fetch_pc_i(fetch_pc_i), .fetch_accept_o(fetch_accept_o),
    .fetch_valid_o(fetch_valid_o), .fetch_inst_o(fetch_inst_o), .mem_ready_i(mem_ready_i),
    .mem_addr_o(mem_addr_o), .mem_wr_o(mem_wr_o), .mem_rd_o(mem_rd_o), .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i), .cpu_rst_o(cpu_rst_o), .load_cnt_o(load_cnt_o),
    .overflow_o(overflow_o), .addr_err_o(addr_err_o)
  );

  typedef struct packed {
    logic [9:0]  a;
    logic [3:0]  we;
    logic [31:0] d;
  } wr_t;

  wr_t         wq[$];
  logic [31:0] fq[$];
  logic [31:0] ram [1024];
  int          n_pass = 0;
  int          n_total = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] dword(input int i);
    return 32'hA5C3_0000 ^ (32'(i) << 20) ^ 32'(i * 3);
  endfunction

  // Synchronous single-port RAM behind the port.
  always @(posedge clk) begin
    if (mem_ready_i) begin
      for (int b = 0; b < 4; b++)
        if (mem_wr_o[b]) ram[mem_addr_o][8*b +: 8] <= mem_data_o[8*b +: 8];
      if (mem_rd_o) mem_data_i <= ram[mem_addr_o];
    end
  end

  always @(negedge clk) begin
    wr_t         e;
    logic [31:0] f;
    if (mem_wr_o != 4'b0) begin
      if (wq.size() == 0) check("wr_unexpected", 64'(mem_wr_o), 64'(0));
      else begin
        e = wq.pop_front();
        check("wr_addr", 64'(mem_addr_o), 64'(e.a));
        check("wr_we",   64'(mem_wr_o),   64'(e.we));
        check("wr_data", 64'(mem_data_o), 64'(e.d));
      end
    end
    if (fetch_valid_o) begin
      if (fq.size() == 0) check("fetch_unexpected", 64'(fetch_inst_o), 64'(0));
      else begin
        f = fq.pop_front();
        check("fetch_inst", 64'(fetch_inst_o), 64'(f));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_in(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d, input bit keep);
    tb_inst_addr_i = a;
    tb_inst_we_i   = we;
    tb_inst_data_i = d;
    if (keep) wq.push_back('{a: a[11:2], we: we, d: d});
  endtask

  task automatic idle_in();
    tb_inst_we_i = 4'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] tmp;
    rst_i = 1'b1; rst_cpu_i = 1'b0; fetch_rd_i = 1'b0; fetch_pc_i = '0;
    mem_ready_i = 1'b1; tb_inst_we_i = '0; tb_inst_addr_i = '0; tb_inst_data_i = '0;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check("rst_cpu_rst",  64'(cpu_rst_o), 64'(1));
    check("rst_load_cnt", 64'(load_cnt_o), 64'(0));
    check("rst_ovf",      64'(overflow_o), 64'(0));
    check("rst_aerr",     64'(addr_err_o), 64'(0));
    check("rst_fvalid",   64'(fetch_valid_o), 64'(0));
    check("rst_mem_addr", 64'(mem_addr_o), 64'(0));
    step();

    // Bulk load, full rate
    for (int i = 0; i < 437; i++) begin
      wr_in(32'(i * 4), 4'hF, dword(i), 1'b1);
      step();
    end
    idle_in();
    repeat (3) step();
    @(negedge clk);
    check("load_cnt_437", 64'(load_cnt_o), 64'(437));
    check("load_cpu_rst", 64'(cpu_rst_o), 64'(1));
    check("load_errs",    64'({overflow_o, addr_err_o}), 64'(0));
    step();

    // Release core: rst_cpu pulse, cpu_rst falls two cycles after the rise
    rst_cpu_i = 1'b1;
    step();
    rst_cpu_i = 1'b0;
    @(negedge clk);
    check("hold_cpu_rst", 64'(cpu_rst_o), 64'(1));
    step();
    @(negedge clk);
    check("run_cpu_rst", 64'(cpu_rst_o), 64'(0));
    step();

    // Back-to-back fetches including a wrapped PC
    fetch_rd_i = 1'b1; fetch_pc_i = 32'h0; fq.push_back(dword(0));
    @(negedge clk); check("fetch0_acc", 64'(fetch_accept_o), 64'(1));
    step();
    fetch_pc_i = 32'h4; fq.push_back(dword(1));
    @(negedge clk); check("fetch1_acc", 64'(fetch_accept_o), 64'(1));
    step();
    fetch_pc_i = 32'h1008; fq.push_back(dword(2));
    @(negedge clk);
    check("fetch_wrap_acc",  64'(fetch_accept_o), 64'(1));
    check("fetch_wrap_addr", 64'(mem_addr_o), 64'(2));
    check("fetch_wrap_rd",   64'(mem_rd_o), 64'(1));
    step();
    fetch_rd_i = 1'b0;
    repeat (2) step();

    // Write and fetch of the same word in one cycle: write wins, fetch sees new data
    wr_in(32'h20, 4'hF, 32'h1234_5678, 1'b1);
    fetch_rd_i = 1'b1; fetch_pc_i = 32'h20;
    @(negedge clk); check("wf_push_stall", 64'(fetch_accept_o), 64'(0));
    step();
    idle_in();
    @(negedge clk); check("wf_commit_stall", 64'(fetch_accept_o), 64'(0));
    step();
    fq.push_back(32'h1234_5678);
    @(negedge clk); check("wf_fetch_acc", 64'(fetch_accept_o), 64'(1));
    step();
    fetch_rd_i = 1'b0;
    step();

    // Partial byte-enable write, then read it back
    wr_in(32'h10, 4'b0011, 32'hDEAD_BEEF, 1'b1);
    step();
    idle_in();
    @(negedge clk);
    check("be_wr",   64'(mem_wr_o), 64'(4'b0011));
    check("be_addr", 64'(mem_addr_o), 64'(4));
    check("be_data", 64'(mem_data_o), 64'(32'hDEAD_BEEF));
    step();
    tmp = dword(4);
    fetch_rd_i = 1'b1; fetch_pc_i = 32'h10; fq.push_back({tmp[31:16], 16'hBEEF});
    @(negedge clk); check("be_fetch_acc", 64'(fetch_accept_o), 64'(1));
    step();
    fetch_rd_i = 1'b0;
    repeat (2) step();

    // Core reset request from RUN: cpu_rst rises the cycle after
    rst_cpu_i = 1'b1;
    @(negedge clk); check("rerun_cpu_rst_before", 64'(cpu_rst_o), 64'(0));
    step();
    rst_cpu_i = 1'b0;
    @(negedge clk); check("rerun_cpu_rst_rise", 64'(cpu_rst_o), 64'(1));
    repeat (2) step();

    // rst_i with three entries pending: all discarded
    mem_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_in(32'h200 + 32'(i * 4), 4'hF, 32'hBAD0_0000 + 32'(i), 1'b0);
      step();
    end
    idle_in();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0; mem_ready_i = 1'b1;
    fetch_rd_i = 1'b1; fetch_pc_i = 32'h0;
    @(negedge clk);
    check("rst2_cpu_rst",  64'(cpu_rst_o), 64'(1));
    check("rst2_load_cnt", 64'(load_cnt_o), 64'(0));
    check("rst2_mem_wr",   64'(mem_wr_o), 64'(0));
    check("rst2_fvalid",   64'(fetch_valid_o), 64'(0));
    check("rst2_load_acc", 64'(fetch_accept_o), 64'(0));
    step();
    fetch_rd_i = 1'b0;
    repeat (4) step();

    // Overflow: six writes with RAM stalled, last two dropped
    mem_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wr_in(32'h100 + 32'(i * 4), 4'hF, dword(100 + i), i < 4);
      step();
    end
    idle_in();
    mem_ready_i = 1'b1;
    @(negedge clk); check("ovf_flag", 64'(overflow_o), 64'(1));
    repeat (5) step();
    @(negedge clk);
    check("ovf_load_cnt", 64'(load_cnt_o), 64'(4));
    check("ovf_aerr",     64'(addr_err_o), 64'(0));
    step();

    // Full FIFO with a simultaneous pop keeps the incoming write
    mem_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_in(32'h180 + 32'(i * 4), 4'hF, dword(200 + i), 1'b1);
      step();
    end
    mem_ready_i = 1'b1;
    wr_in(32'h190, 4'hF, dword(204), 1'b1);
    step();
    idle_in();
    repeat (6) step();
    @(negedge clk);
    check("fullpop_load_cnt", 64'(load_cnt_o), 64'(9));
    step();

    // Address range: out-of-range dropped, last valid word kept
    wr_in(32'hFFFF_FFF0, 4'hF, 32'h0BAD_0BAD, 1'b0);
    step();
    idle_in();
    @(negedge clk);
    check("aerr_flag", 64'(addr_err_o), 64'(1));
    check("aerr_no_wr", 64'(mem_wr_o), 64'(0));
    step();
    wr_in(32'h1000, 4'hF, 32'h0BAD_1000, 1'b0);
    step();
    wr_in(32'hFFC, 4'hF, 32'h600D_0FFC, 1'b1);
    step();
    idle_in();
    repeat (3) step();
    @(negedge clk);
    check("aerr_load_cnt", 64'(load_cnt_o), 64'(10));
    check("sticky_ovf",    64'(overflow_o), 64'(1));
    check("wq_drained", 64'(wq.size()), 64'(0));
    check("fq_drained", 64'(fq.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
